// File: rtl/dispatch_queue_pkg.sv
// Shared opcode encodings and decode helpers for the dispatch queue.
// Exports opcode localparams, class predicates and reserved-code helpers.
package rv_dispatch_pkg;

    localparam logic [6:0] lui   = 7'd1;
    localparam logic [6:0] auipc = 7'd2;
    localparam logic [6:0] jal   = 7'd3;
    localparam logic [6:0] jalr  = 7'd4;
    localparam logic [6:0] beq   = 7'd5;
    localparam logic [6:0] bne   = 7'd6;
    localparam logic [6:0] blt   = 7'd7;
    localparam logic [6:0] bge   = 7'd8;
    localparam logic [6:0] bltu  = 7'd9;
    localparam logic [6:0] bgeu  = 7'd10;
    localparam logic [6:0] lb    = 7'd11;
    localparam logic [6:0] lh    = 7'd12;
    localparam logic [6:0] lw    = 7'd13;
    localparam logic [6:0] lbu   = 7'd14;
    localparam logic [6:0] lhu   = 7'd15;
    localparam logic [6:0] sb    = 7'd16;
    localparam logic [6:0] sh    = 7'd17;
    localparam logic [6:0] sw    = 7'd18;
    localparam logic [6:0] addi  = 7'd19;
    localparam logic [6:0] slti  = 7'd20;
    localparam logic [6:0] sltiu = 7'd21;
    localparam logic [6:0] xori  = 7'd22;
    localparam logic [6:0] ori   = 7'd23;
    localparam logic [6:0] andi  = 7'd24;
    localparam logic [6:0] slli  = 7'd25;
    localparam logic [6:0] srli  = 7'd26;
    localparam logic [6:0] srai  = 7'd27;
    localparam logic [6:0] add   = 7'd28;
    localparam logic [6:0] sub   = 7'd29;
    localparam logic [6:0] sll   = 7'd30;
    localparam logic [6:0] slt   = 7'd31;
    localparam logic [6:0] sltu  = 7'd32;
    localparam logic [6:0] xorr  = 7'd33;
    localparam logic [6:0] srl   = 7'd34;
    localparam logic [6:0] sra   = 7'd35;
    localparam logic [6:0] orr   = 7'd36;
    localparam logic [6:0] andd  = 7'd37;

    function automatic logic is_mem(input logic [6:0] op);
        return (op >= lb) && (op <= sw);
    endfunction

    function automatic logic is_store_or_branch(input logic [6:0] op);
        return ((op >= beq) && (op <= bgeu)) || ((op >= sb) && (op <= sw));
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == lui) || (op == auipc) || (op == jal));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return ((op >= beq) && (op <= bgeu)) ||
               ((op >= sb) && (op <= sw)) ||
               ((op >= add) && (op <= andd));
    endfunction

    // Reserved "no register" / "no dependency" codes: the MSB of the
    // widened index set, all lower bits clear.
    function automatic int unsigned non_reg_code(input int unsigned w);
        return 32'd1 << w;
    endfunction

    function automatic int unsigned non_dep_code(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Decoder -> dispatch queue valid/ready bundle.
// master: decoder drives payload + valid; slave: queue drives ready.
interface dq_dec_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5
);
    logic                  DCDP_valid;
    logic                  DCDP_ready;
    logic [ADDR_WIDTH-1:0] DCDP_pc;
    logic [6:0]            DCDP_opcode;
    logic [REG_WIDTH-1:0]  DCDP_rs1;
    logic [REG_WIDTH-1:0]  DCDP_rs2;
    logic [REG_WIDTH-1:0]  DCDP_rd;
    logic [31:0]           DCDP_imm;
    logic                  DCDP_pred;

    modport master (
        output DCDP_valid, DCDP_pc, DCDP_opcode, DCDP_rs1,
        output DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_pred,
        input  DCDP_ready
    );

    modport slave (
        input  DCDP_valid, DCDP_pc, DCDP_opcode, DCDP_rs1,
        input  DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_pred,
        output DCDP_ready
    );
endinterface

// File: rtl/dispatch_queue_fifo.sv
// dq_fifo: synchronous FIFO with single-cycle flush.
// Ports: clk, rst_n, flush, push/din, pop/dout, full, empty.
module dq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full/empty differ by the MSB.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q[AW-1:0]] = din;
                wr_d = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instrs, resolves operands, issues 1/cycle.
// Ports: Sys_*, decoder bundle (dec), RF/RoB/RS/LSB/CDB side, DPEX_* payload.
module dispatch_queue
    import rv_dispatch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int RoB_WIDTH  = 8,
    parameter int ROB_SIZE   = 256,
    parameter int DQ_DEPTH   = 4,
    parameter int CDB_PORTS  = 2
) (
    input  logic                      Sys_clk,
    input  logic                      Sys_rst_n,
    input  logic                      Sys_rdy,
    dq_dec_if.slave                   dec,
    output logic [REG_WIDTH:0]        DPRF_rs1,
    output logic [REG_WIDTH:0]        DPRF_rs2,
    input  logic [RoB_WIDTH:0]        RFDP_Qj,
    input  logic [RoB_WIDTH:0]        RFDP_Qk,
    input  logic [31:0]               RFDP_Vj,
    input  logic [31:0]               RFDP_Vk,
    output logic [RoB_WIDTH:0]        DPRoB_Qj,
    output logic [RoB_WIDTH:0]        DPRoB_Qk,
    input  logic                      RoBDP_Qj_ready,
    input  logic                      RoBDP_Qk_ready,
    input  logic [31:0]               RoBDP_Vj,
    input  logic [31:0]               RoBDP_Vk,
    input  logic [RoB_WIDTH-1:0]      RoBDP_RoB_index,
    input  logic                      RoBDP_full,
    input  logic                      RSDP_full,
    input  logic                      LSBDP_full,
    input  logic                      RoBDP_flush,
    input  logic [CDB_PORTS-1:0]      CDBDP_en,
    input  logic [CDB_PORTS*RoB_WIDTH-1:0] CDBDP_RoB_index,
    input  logic [CDB_PORTS*32-1:0]   CDBDP_value,
    output logic                      DPRF_en,
    output logic                      DPRoB_en,
    output logic                      DPRS_en,
    output logic                      DPLSB_en,
    output logic [ADDR_WIDTH-1:0]     DPEX_pc,
    output logic [6:0]                DPEX_opcode,
    output logic [REG_WIDTH:0]        DPEX_rd,
    output logic                      DPEX_pred,
    output logic [31:0]               DPEX_imm,
    output logic [RoB_WIDTH:0]        DPEX_Qj,
    output logic [RoB_WIDTH:0]        DPEX_Qk,
    output logic [31:0]               DPEX_Vj,
    output logic [31:0]               DPEX_Vk,
    output logic [RoB_WIDTH-1:0]      DPEX_RoB_index
);
    localparam int EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
    localparam logic [EX_REG_WIDTH-1:0] NON_REG =
        EX_REG_WIDTH'(non_reg_code(REG_WIDTH));
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP =
        EX_RoB_WIDTH'(non_dep_code(RoB_WIDTH));
    localparam logic [RoB_WIDTH-1:0] ROB_LAST = RoB_WIDTH'(ROB_SIZE - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [6:0]            opcode;
        logic [REG_WIDTH-1:0]  rs1;
        logic [REG_WIDTH-1:0]  rs2;
        logic [REG_WIDTH-1:0]  rd;
        logic [31:0]           imm;
        logic                  pred;
    } entry_t;

    typedef struct packed {
        logic [EX_RoB_WIDTH-1:0] q;
        logic [31:0]             v;
    } opnd_t;

    entry_t wr_entry, head;
    logic   fifo_full, fifo_empty;
    logic   push, issue, fifo_flush, head_mem;
    logic [RoB_WIDTH-1:0]    rob_idx;
    logic [EX_REG_WIDTH-1:0] rd_ex;
    opnd_t  opj, opk;

    // The last issued index/rd live in the payload flops, so the rename
    // bypass only needs last_valid on top of them.
    logic en_q, en_d, rs_en_q, rs_en_d, lsb_en_q, lsb_en_d;
    logic last_valid_q, last_valid_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [6:0]              opcode_q, opcode_d;
    logic [EX_REG_WIDTH-1:0] rd_q, rd_d;
    logic                    pred_q, pred_d;
    logic [31:0]             imm_q, imm_d;
    logic [EX_RoB_WIDTH-1:0] qj_q, qj_d, qk_q, qk_d;
    logic [31:0]             vj_q, vj_d, vk_q, vk_d;
    logic [RoB_WIDTH-1:0]    idx_q, idx_d;

    assign wr_entry = '{
        pc:     dec.DCDP_pc,
        opcode: dec.DCDP_opcode,
        rs1:    dec.DCDP_rs1,
        rs2:    dec.DCDP_rs2,
        rd:     dec.DCDP_rd,
        imm:    dec.DCDP_imm,
        pred:   dec.DCDP_pred
    };

    assign dec.DCDP_ready = !fifo_full;
    assign fifo_flush = Sys_rdy & RoBDP_flush;
    assign push = Sys_rdy & dec.DCDP_valid & !fifo_full & !RoBDP_flush;
    assign head_mem = is_mem(head.opcode);
    assign issue = Sys_rdy & !fifo_empty & !RoBDP_full & !RoBDP_flush &
                   !(head_mem ? LSBDP_full : RSDP_full);

    dq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DQ_DEPTH)
    ) u_fifo (
        .clk   (Sys_clk),
        .rst_n (Sys_rst_n),
        .flush (fifo_flush),
        .push  (push),
        .pop   (issue),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign DPRF_rs1 = uses_rs1(head.opcode) ? {1'b0, head.rs1} : NON_REG;
    assign DPRF_rs2 = uses_rs2(head.opcode) ? {1'b0, head.rs2} : NON_REG;
    assign DPRoB_Qj = RFDP_Qj;
    assign DPRoB_Qk = RFDP_Qk;

    always_comb begin
        rob_idx = RoBDP_RoB_index;
        if (last_valid_q) begin
            rob_idx = (idx_q == ROB_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign rd_ex = (is_store_or_branch(head.opcode) || head.rd == '0)
                 ? NON_REG : {1'b0, head.rd};

    function automatic opnd_t resolve(
        input logic                    used,
        input logic [REG_WIDTH-1:0]    rs,
        input logic [EX_RoB_WIDTH-1:0] rf_q,
        input logic [31:0]             rf_v,
        input logic                    rob_rdy,
        input logic [31:0]             rob_v
    );
        opnd_t r;
        r.q = rf_q;
        r.v = rf_v;
        if (!used || rs == '0) begin
            r.q = NON_DEP;
            r.v = '0;
        end else if (last_valid_q && rd_q == {1'b0, rs}) begin
            r.q = {1'b0, idx_q};
            r.v = '0;
        end else if (rf_q == NON_DEP) begin
            r.v = rf_v;
        end else if (rob_rdy) begin
            r.q = NON_DEP;
            r.v = rob_v;
        end else begin
            // Descending scan so the lowest matching channel wins.
            for (int i = CDB_PORTS - 1; i >= 0; i--) begin
                if (CDBDP_en[i] &&
                    CDBDP_RoB_index[i*RoB_WIDTH +: RoB_WIDTH]
                        == rf_q[RoB_WIDTH-1:0]) begin
                    r.q = NON_DEP;
                    r.v = CDBDP_value[i*32 +: 32];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        opj = resolve(uses_rs1(head.opcode), head.rs1,
                      RFDP_Qj, RFDP_Vj, RoBDP_Qj_ready, RoBDP_Vj);
        opk = resolve(uses_rs2(head.opcode), head.rs2,
                      RFDP_Qk, RFDP_Vk, RoBDP_Qk_ready, RoBDP_Vk);
    end

    always_comb begin
        en_d         = issue;
        rs_en_d      = issue & !head_mem;
        lsb_en_d     = issue & head_mem;
        last_valid_d = Sys_rdy ? issue : last_valid_q;
        pc_d         = pc_q;
        opcode_d     = opcode_q;
        rd_d         = rd_q;
        pred_d       = pred_q;
        imm_d        = imm_q;
        qj_d         = qj_q;
        qk_d         = qk_q;
        vj_d         = vj_q;
        vk_d         = vk_q;
        idx_d        = idx_q;
        if (issue) begin
            pc_d     = head.pc;
            opcode_d = head.opcode;
            rd_d     = rd_ex;
            pred_d   = head.pred;
            imm_d    = head.imm;
            qj_d     = opj.q;
            qk_d     = opk.q;
            vj_d     = opj.v;
            vk_d     = opk.v;
            idx_d    = rob_idx;
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            en_q         <= 1'b0;
            rs_en_q      <= 1'b0;
            lsb_en_q     <= 1'b0;
            last_valid_q <= 1'b0;
            pc_q         <= '0;
            opcode_q     <= '0;
            rd_q         <= NON_REG;
            pred_q       <= 1'b0;
            imm_q        <= '0;
            qj_q         <= NON_DEP;
            qk_q         <= NON_DEP;
            vj_q         <= '0;
            vk_q         <= '0;
            idx_q        <= '0;
        end else begin
            en_q         <= en_d;
            rs_en_q      <= rs_en_d;
            lsb_en_q     <= lsb_en_d;
            last_valid_q <= last_valid_d;
            pc_q         <= pc_d;
            opcode_q     <= opcode_d;
            rd_q         <= rd_d;
            pred_q       <= pred_d;
            imm_q        <= imm_d;
            qj_q         <= qj_d;
            qk_q         <= qk_d;
            vj_q         <= vj_d;
            vk_q         <= vk_d;
            idx_q        <= idx_d;
        end
    end

    assign DPRF_en        = en_q;
    assign DPRoB_en       = en_q;
    assign DPRS_en        = rs_en_q;
    assign DPLSB_en       = lsb_en_q;
    assign DPEX_pc        = pc_q;
    assign DPEX_opcode    = opcode_q;
    assign DPEX_rd        = rd_q;
    assign DPEX_pred      = pred_q;
    assign DPEX_imm       = imm_q;
    assign DPEX_Qj        = qj_q;
    assign DPEX_Qk        = qk_q;
    assign DPEX_Vj        = vj_q;
    assign DPEX_Vk        = vk_q;
    assign DPEX_RoB_index = idx_q;
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
Parametrised successor to the single-slot dispatcher. It sits between Decoder and the RS/LSB/RoB/RF.
- Buffers decoded instructions in a DQ_DEPTH-entry FIFO with a valid/ready handshake.
- Issues one instruction per cycle, back-to-back, with no ask/wait round trip.
- Resolves operands from RF, RoB, a same-cycle rename bypass and CDB_PORTS broadcast channels.
- Flushes on a mispredict.

Parameters:
ADDR_WIDTH, 32, pc width
REG_WIDTH, 5, arch register index width; EX_REG_WIDTH = REG_WIDTH+1, NON_REG = 1<<REG_WIDTH (derived localparams)
RoB_WIDTH, 8, RoB index width; EX_RoB_WIDTH = RoB_WIDTH+1, NON_DEP = 1<<RoB_WIDTH (derived)
ROB_SIZE, 256, RoB entries (≤ 2^RoB_WIDTH); allocation index wraps ROB_SIZE-1 -> 0
DQ_DEPTH, 4, FIFO entries, power of 2, ≥2
CDB_PORTS, 2, number of CDB broadcast channels

Ports:
Sys_clk  in  1  clock
Sys_rst_n  in  1  asynchronous active-low reset
Sys_rdy  in  1  global enable; when low all state holds and enables are forced 0
DCDP_valid / DCDP_ready  in / out  1 / 1  decoder handshake; transfer when both high at posedge
DCDP_pc, DCDP_opcode, DCDP_rs1, DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_pred  in  ADDR_WIDTH, 7, REG_WIDTH x3, 32, 1  decoded instruction
DPRF_rs1, DPRF_rs2  out  EX_REG_WIDTH  combinational RF read of head (NON_REG if unused)
RFDP_Qj, RFDP_Qk / RFDP_Vj, RFDP_Vk  in  EX_RoB_WIDTH / 32  RF rename tag and value
DPRoB_Qj, DPRoB_Qk  out  EX_RoB_WIDTH  combinational copies of RFDP_Qj/Qk
RoBDP_Qj_ready, RoBDP_Qk_ready / RoBDP_Vj, RoBDP_Vk  in  1 / 32  RoB has value
RoBDP_RoB_index  in  RoB_WIDTH  RoB tail index
RoBDP_full, RSDP_full, LSBDP_full  in  1  asserted when free entries ≤ 1
RoBDP_flush  in  1  mispredict, active high
CDBDP_en  in  CDB_PORTS  per-channel valid
CDBDP_RoB_index  in  CDB_PORTS*RoB_WIDTH  packed per-channel tags, channel i at [i*RoB_WIDTH +: RoB_WIDTH]
CDBDP_value  in  CDB_PORTS*32  packed per-channel values
DPRF_en, DPRoB_en, DPRS_en, DPLSB_en  out  1  registered one-cycle issue strobes
DPEX_pc, DPEX_opcode, DPEX_rd, DPEX_pred, DPEX_imm  out  ADDR_WIDTH, 7, EX_REG_WIDTH, 1, 32  shared issue payload
DPEX_Qj, DPEX_Qk / DPEX_Vj, DPEX_Vk / DPEX_RoB_index  out  EX_RoB_WIDTH / 32 / RoB_WIDTH  resolved operands and RoB index

Behaviour:
- Reset values:
  - FIFO empty; DCDP_ready=1; all enables 0.
  - DPEX_Qj and DPEX_Qk = NON_DEP; DPEX_rd = NON_REG; every other payload output 0.
  - last_valid=0.
- DCDP_ready = !fifo_full. It does not consider a same-cycle dequeue. Enqueue while full is impossible.
- Issue condition (cycle t): Sys_rdy & !empty & !RoBDP_full & !RoBDP_flush & !(is_mem ? LSBDP_full : RSDP_full).
- On issue, at posedge end of t:
  - Pop the head.
  - DPRF_en = DPRoB_en = 1, plus exactly one of DPRS_en / DPLSB_en; payload registered.
  - Strobes drop next cycle unless another issue occurs.
- Throughput and latency: 1 instr/cycle. Decoder acceptance -> issue strobes visible ≥ 2 cycles later.
- RoB index = last_valid ? wrap(last_idx+1) : RoBDP_RoB_index.
  - last_valid is set by an issue and cleared by a non-issue cycle or a flush.
- DPEX_rd:
  - NON_REG for branches and stores.
  - NON_REG for rd==0.
  - DCDP_rd otherwise.
- Operand resolution, per operand, first match wins:
  1. rs unused or rs==0: Q=NON_DEP, V=0.
  2. last_valid & last_rd==rs: Q=last_idx (rename bypass; covers the RF write still in flight).
  3. RF Q==NON_DEP: V=RF V.
  4. RoB ready: V=RoB V, Q=NON_DEP.
  5. Lowest-numbered CDB channel with en & tag==Q: V=that value, Q=NON_DEP.
  6. Otherwise: Q=RF Q, V=RF V.
- Flush (RoBDP_flush=1 at posedge) takes priority over all other events:
  - FIFO emptied; a same-cycle enqueue is dropped.
  - All strobes 0 next cycle; last_valid=0.
  - DCDP_ready=1 next cycle.
- Reset asserted mid-operation: all state clears immediately, asynchronously, to the reset values above.
- FIFO pointers are log2(DQ_DEPTH)+1 bits; full and empty are distinguished by the MSB.

Decomposition:
- Package rv_dispatch_pkg holds:
  - Opcode localparams (lui=1 … andd=37).
  - Functions is_mem, is_store_or_branch, uses_rs1, uses_rs2.
  - NON_REG / NON_DEP helpers.
- Sub-module dq_fifo(WIDTH, DEPTH): synchronous FIFO with flush. The operand resolver stays inline as a combinational block.

Test Plan:
- Back-to-back RAW: addi x1,x0,5 then add x2,x1,x1 with RoBDP_RoB_index=7 -> second issue has DPEX_RoB_index=8, Qj=Qk=7.
- CDB forward: head add with RFDP_Qj=3 and CDBDP_en[1]=1, tag 3, value 0xDEAD on the issue cycle -> DPEX_Qj=NON_DEP, DPEX_Vj=0xDEAD.
- Back-pressure: LSBDP_full=1 with head lw -> no strobe, FIFO fills to 4, DCDP_ready=0. Release -> lw issues with DPLSB_en=1, DPRS_en=0.
- Wrap: ROB_SIZE=256, last_idx=255, consecutive issue -> DPEX_RoB_index=0.
- Flush with 3 entries queued while DCDP_valid=1 -> next cycle FIFO empty, strobes 0, enqueue dropped. The next issue uses RoBDP_RoB_index.
- Async reset asserted mid-issue -> DPRS_en=0 before the next clock edge. sw -> DPEX_rd=NON_REG.
